compare_pipe: RTL and testbench

- Parametrised, pipelined magnitude comparator for streamed operand pairs.
- Each cycle it accepts an A/B pair with a valid strobe. Two cycles later it produces registered one-hot greater/equal/less flags.
- Keeps saturating per-outcome event counters for status readout.
- Sits between a datapath source and the status/display logic; it is the general-width, signed-capable successor to the 4-bit combinational comparator.

---
 rtl/cmp_pkg.sv | 29 ++
 rtl/compare_pipe_if.sv | 51 +++++
 rtl/cmp_core.sv | 37 +++
 rtl/compare_pipe.sv | 131 +++++++++++++
 tb/tb_compare_pipe.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// ============================================================================
// Module : cmp_pkg
// Brief  : Shared result encoding, default sizes and saturating increment
//          for the compare_pipe comparator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

    localparam int CMP_DEF_WIDTH = 8;
    localparam int CMP_DEF_CNT_W = 16;

    typedef logic [1:0] cmp_res_t;

    localparam cmp_res_t CMP_LT = 2'b00;
    localparam cmp_res_t CMP_EQ = 2'b01;
    localparam cmp_res_t CMP_GT = 2'b10;

    // Counter is carried in a 64-bit container; w is the real counter width.
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (cnt >= lim) ? cnt : cnt + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/compare_pipe_if.sv
// ============================================================================
// Module : compare_pipe_if
// Brief  : Operand stream, flag and status bundle for compare_pipe.
//          Min/max signals exist only with COMPARE_PIPE_MINMAX_EN defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface compare_pipe_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_DEF_WIDTH,
    parameter int CNT_W = CMP_DEF_CNT_W
);
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic             clr_cnt;
    logic             out_valid;
    logic             oa;
    logic             oe;
    logic             ob;
    logic [CNT_W-1:0] cnt_gt;
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_lt;
`ifdef COMPARE_PIPE_MINMAX_EN
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] min_val;
    logic             mm_valid;
`endif

    modport master (
        output in_valid, in_a, in_b, in_signed, clr_cnt,
        input  out_valid, oa, oe, ob, cnt_gt, cnt_eq, cnt_lt
`ifdef COMPARE_PIPE_MINMAX_EN
        , input max_val, min_val, mm_valid
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, clr_cnt,
        output out_valid, oa, oe, ob, cnt_gt, cnt_eq, cnt_lt
`ifdef COMPARE_PIPE_MINMAX_EN
        , output max_val, min_val, mm_valid
`endif
    );

endinterface

`default_nettype wire

// File: rtl/cmp_core.sv
// ============================================================================
// Module : cmp_core
// Brief  : Combinational WIDTH-bit magnitude compare, signed or unsigned.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_DEF_WIDTH
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_signed_mode,
    output cmp_res_t              o_res
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_a = {i_a[WIDTH-1] ^ i_signed_mode, i_a[WIDTH-2:0]};
    assign w_b = {i_b[WIDTH-1] ^ i_signed_mode, i_b[WIDTH-2:0]};

    always_comb begin
        o_res = CMP_LT;
        if (w_a > w_b) begin
            o_res = CMP_GT;
        end else if (w_a == w_b) begin
            o_res = CMP_EQ;
        end
    end

endmodule

`default_nettype wire

// File: rtl/compare_pipe.sv
// ============================================================================
// Module : compare_pipe
// Brief  : Two-stage pipelined magnitude comparator with saturating outcome
//          counters. COMPARE_PIPE_MINMAX_EN adds running max/min of operand A.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module compare_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_DEF_WIDTH,
    parameter int CNT_W = CMP_DEF_CNT_W
) (
    input wire logic     clk,
    input wire logic     rst,
    compare_pipe_if.slave bus
);

    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_signed;
    logic             r_s1_valid;
    logic             r_out_valid;
    logic             r_oa;
    logic             r_oe;
    logic             r_ob;
    logic [CNT_W-1:0] r_cnt_gt;
    logic [CNT_W-1:0] r_cnt_eq;
    logic [CNT_W-1:0] r_cnt_lt;
    cmp_res_t         w_res;

    // Operands hold their value between valid pairs to avoid needless toggling.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            r_s1_a      <= bus.in_a;
            r_s1_b      <= bus.in_b;
            r_s1_signed <= bus.in_signed;
        end
    end

    cmp_core #(.WIDTH(WIDTH)) u_cmp (
        .i_a           (r_s1_a),
        .i_b           (r_s1_b),
        .i_signed_mode (r_s1_signed),
        .o_res         (w_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_oa        <= 1'b0;
            r_oe        <= 1'b0;
            r_ob        <= 1'b0;
        end else begin
            r_s1_valid  <= bus.in_valid;
            r_out_valid <= r_s1_valid;
            r_oa        <= r_s1_valid && (w_res == CMP_GT);
            r_oe        <= r_s1_valid && (w_res == CMP_EQ);
            r_ob        <= r_s1_valid && (w_res == CMP_LT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            r_cnt_gt <= '0;
            r_cnt_eq <= '0;
            r_cnt_lt <= '0;
        end else if (r_s1_valid) begin
            case (w_res)
                CMP_GT:  r_cnt_gt <= CNT_W'(sat_inc(64'(r_cnt_gt), CNT_W));
                CMP_EQ:  r_cnt_eq <= CNT_W'(sat_inc(64'(r_cnt_eq), CNT_W));
                default: r_cnt_lt <= CNT_W'(sat_inc(64'(r_cnt_lt), CNT_W));
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.oa        = r_oa;
    assign bus.oe        = r_oe;
    assign bus.ob        = r_ob;
    assign bus.cnt_gt    = r_cnt_gt;
    assign bus.cnt_eq    = r_cnt_eq;
    assign bus.cnt_lt    = r_cnt_lt;

`ifdef COMPARE_PIPE_MINMAX_EN
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic             r_mm_valid;
    cmp_res_t         w_res_max;
    cmp_res_t         w_res_min;

    cmp_core #(.WIDTH(WIDTH)) u_cmp_max (
        .i_a           (r_s1_a),
        .i_b           (r_max),
        .i_signed_mode (r_s1_signed),
        .o_res         (w_res_max)
    );

    cmp_core #(.WIDTH(WIDTH)) u_cmp_min (
        .i_a           (r_s1_a),
        .i_b           (r_min),
        .i_signed_mode (r_s1_signed),
        .o_res         (w_res_min)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            r_max      <= '0;
            r_min      <= '0;
            r_mm_valid <= 1'b0;
        end else if (r_s1_valid) begin
            r_mm_valid <= 1'b1;
            if (!r_mm_valid || (w_res_max == CMP_GT)) begin
                r_max <= r_s1_a;
            end
            if (!r_mm_valid || (w_res_min == CMP_LT)) begin
                r_min <= r_s1_a;
            end
        end
    end

    assign bus.max_val  = r_max;
    assign bus.min_val  = r_min;
    assign bus.mm_valid = r_mm_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_compare_pipe.sv
// ============================================================================
// Module : tb_compare_pipe
// Brief  : Scoreboard bench for compare_pipe (main 8/16 instance plus a
//          CNT_W=2 instance for saturation). Covers COMPARE_PIPE_MINMAX_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_compare_pipe;

    typedef struct {
        logic [2:0] flags;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   pulses = 0;
    int   m_gt = 0;
    int   m_eq = 0;
    int   m_lt = 0;
    exp_t sb[$];
    exp_t e;

    compare_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
    compare_pipe_if #(.WIDTH(8), .CNT_W(2))  bus_s ();

    compare_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    compare_pipe #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input logic s);
        if (s) begin
            if ($signed(a) > $signed(b)) return 3'b100;
            if (a == b)                  return 3'b010;
            return 3'b001;
        end
        if (a > b)  return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t x;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        x.flags = ref_flags(a, b, s);
        x.cyc   = cyc + 2;
        sb.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_cnts(input string tag, input int gt, input int eq, input int lt);
        chk({tag, "_cnt_gt"}, 64'(bus.cnt_gt), 64'(gt));
        chk({tag, "_cnt_eq"}, 64'(bus.cnt_eq), 64'(eq));
        chk({tag, "_cnt_lt"}, 64'(bus.cnt_lt), 64'(lt));
    endtask

    // Output monitor: every pulse must match the oldest outstanding pair.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                pulses++;
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("flags", {61'd0, bus.oa, bus.oe, bus.ob}, {61'd0, e.flags});
                if (e.flags[2]) m_gt++;
                if (e.flags[1]) m_eq++;
                if (e.flags[0]) m_lt++;
            end
        end else begin
            chk("idle_flags", {61'd0, bus.oa, bus.oe, bus.ob}, 64'd0);
        end
    end

    initial begin
        int p0;
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.in_signed   = 1'b0;
        bus.clr_cnt     = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.in_a      = '0;
        bus_s.in_b      = '0;
        bus_s.in_signed = 1'b0;
        bus_s.clr_cnt   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk_cnts("rst", 0, 0, 0);
        rst = 1'b0;
        idle(2);

        // Unsigned basics
        send(8'h05, 8'h03, 1'b0);
        send(8'h03, 8'h03, 1'b0);
        send(8'h00, 8'hFF, 1'b0);
        idle(4);
        chk_cnts("basic", 1, 1, 1);

        // Signed vs unsigned on the same operands
        send(8'h80, 8'h7F, 1'b1);
        send(8'h80, 8'h7F, 1'b0);
        send(8'hFF, 8'hFE, 1'b1);
        idle(4);
        chk_cnts("signed", 3, 1, 2);

        bus.clr_cnt = 1'b1;
        idle(1);
        bus.clr_cnt = 1'b0;
        idle(1);
        chk_cnts("clear", 0, 0, 0);
        m_gt = 0; m_eq = 0; m_lt = 0;

        // Streaming back-to-back with random sign mode
        p0 = pulses;
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(4);
        chk("stream_pulses", 64'(pulses - p0), 64'd100);
        chk("stream_sum", 64'(bus.cnt_gt) + 64'(bus.cnt_eq) + 64'(bus.cnt_lt), 64'd100);
        chk_cnts("stream", m_gt, m_eq, m_lt);

        // Clear lands during an out_valid cycle; next result completes at the clear edge
        send(8'h20, 8'h10, 1'b0);
        send(8'h10, 8'h20, 1'b0);
        bus.in_valid = 1'b0;
        bus.clr_cnt  = 1'b1;
        chk("clr_coincide_valid", 64'(bus.out_valid), 64'd1);
        idle(1);
        bus.clr_cnt = 1'b0;
        idle(3);
        chk_cnts("clr_collide", 0, 0, 0);
        m_gt = 0; m_eq = 0; m_lt = 0;

        // Reset one cycle after a pair is accepted: pair must vanish
        p0 = pulses;
        send(8'h44, 8'h11, 1'b0);
        rst = 1'b1;
        sb.delete();
        idle(2);
        rst = 1'b0;
        idle(4);
        chk("rst_drop_pulses", 64'(pulses - p0), 64'd0);
        chk("rst_drop_valid", 64'(bus.out_valid), 64'd0);
        chk_cnts("rst_drop", 0, 0, 0);

        // Saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            bus_s.in_valid  = 1'b1;
            bus_s.in_a      = 8'h5A;
            bus_s.in_b      = 8'h5A;
            bus_s.in_signed = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus_s.in_valid = 1'b0;
        idle(4);
        chk("sat_cnt_eq", 64'(bus_s.cnt_eq), 64'd3);
        chk("sat_cnt_gt", 64'(bus_s.cnt_gt), 64'd0);
        chk("sat_cnt_lt", 64'(bus_s.cnt_lt), 64'd0);

`ifdef COMPARE_PIPE_MINMAX_EN
        bus.clr_cnt = 1'b1;
        idle(1);
        bus.clr_cnt = 1'b0;
        idle(1);
        chk("mm_valid_clr", 64'(bus.mm_valid), 64'd0);
        send(8'h10, 8'h00, 1'b1);
        send(8'hF0, 8'h00, 1'b1);
        send(8'h7F, 8'h00, 1'b1);
        idle(4);
        chk("mm_max", 64'(bus.max_val), 64'h7F);
        chk("mm_min", 64'(bus.min_val), 64'hF0);
        chk("mm_valid", 64'(bus.mm_valid), 64'd1);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
